// File: rtl/uart_tx.sv
// uart_tx: serial transmitter framing START, DATA_WIDTH data bits LSB first, STOP.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and STOP.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
    localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state;
    logic [15:0]           baud;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  bit_end;

    assign bit_end = (baud == BAUD_LAST);

    // tx is loaded one cycle ahead of each bit so the line changes exactly on the bit boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= START;
                        shreg   <= data_in;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        baud    <= '0;
                        bit_idx <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud  <= '0;
                        state <= DATA;
                        tx    <= shreg[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= ^shreg;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[bit_idx + 1'b1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud  <= '0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        baud  <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues payloads, a negedge monitor checks every line cycle.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_LEN   = (2 + DW + PAR) * CPB;
    localparam int CPB_B       = 2;
    localparam int DW_B        = 5;
    localparam int FRAME_LEN_B = (2 + DW_B + PAR) * CPB_B;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [DW-1:0]   data_in = '0;
    logic            tx, busy, done;
    logic            start_b = 1'b0;
    logic [DW_B-1:0] data_b = '0;
    logic            tx_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .tx(tx), .busy(busy), .done(done)
    );

    uart_tx #(.CLKS_PER_BIT(CPB_B), .DATA_WIDTH(DW_B)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .data_in(data_b),
        .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Line level for serial bit slot idx of a frame carrying d.
    function automatic logic frame_bit(input logic [31:0] d, input int width, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= width) return d[idx-1];
        if (PAR == 1 && idx == width + 1) return ^d;
        return 1'b1;
    endfunction

    bit            in_frame = 1'b0;
    bit            done_due = 1'b0;
    int            pos = 0;
    logic [DW-1:0] cur = '0;

    always @(negedge clk) begin
        if (reset) begin
            check("reset_tx", tx, 1);
            check("reset_busy", busy, 0);
            check("reset_done", done, 0);
            in_frame = 1'b0;
            done_due = 1'b0;
        end else begin
            check("done", done, done_due);
            done_due = 1'b0;
            if (!in_frame && busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame at %0t: got busy=1, expected no frame", $time);
                    cur = '0;
                end else begin
                    cur = exp_q.pop_front();
                end
                in_frame = 1'b1;
                pos = 0;
            end
            if (in_frame) begin
                check("frame_busy", busy, 1);
                check("frame_tx", tx, frame_bit(32'(cur), DW, pos / CPB));
                if (pos == FRAME_LEN - 1) begin
                    in_frame = 1'b0;
                    done_due = 1'b1;
                end else begin
                    pos++;
                end
            end else begin
                check("idle_busy", busy, 0);
                check("idle_tx", tx, 1);
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input bit accepted);
        start = 1'b1;
        data_in = d;
        if (accepted) exp_q.push_back(d);
        @(posedge clk); #1;
        start = 1'b0;
        data_in = DW'($urandom);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] d;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        send(8'hA5, 1); wait_cycles(FRAME_LEN + 2);
        send(8'h07, 1); wait_cycles(FRAME_LEN + 2);

        // second strobe lands 10 cycles into the frame and must be dropped
        send(8'hA5, 1); wait_cycles(9); send(8'h3C, 0); wait_cycles(FRAME_LEN);

        // next strobe coincides with the done cycle
        send(8'hA5, 1); wait_cycles(FRAME_LEN); send(8'h0F, 1); wait_cycles(FRAME_LEN + 2);

        // reset while data bit 3 (a 0) is on the line
        send(8'hC3, 1); wait_cycles(16);
        #1 reset = 1'b1;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        send(8'h55, 0);
        wait_cycles(2);
        reset = 1'b0;
        send(8'h96, 1); wait_cycles(FRAME_LEN + 2);

        for (int i = 0; i < 20; i++) begin
            d = DW'($urandom);
            send(d, 1);
            wait_cycles(FRAME_LEN + int'($urandom_range(0, 3)));
        end
        wait_cycles(4);
        check("queue_empty", exp_q.size(), 0);

        data_b = 5'h1F;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int i = 0; i < FRAME_LEN_B; i++) begin
            @(negedge clk);
            check("b_tx", tx_b, frame_bit(32'h1F, DW_B, i / CPB_B));
            check("b_busy", busy_b, 1);
        end
        @(negedge clk);
        check("b_done", done_b, 1);
        check("b_busy_end", busy_b, 0);
        check("b_tx_idle", tx_b, 1);
        @(negedge clk);
        check("b_done_once", done_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16; clock cycles per serial bit, legal range 2..65535.
REQ-002 SHALL have parameter DATA_WIDTH, default 8; payload bits per frame, legal range 5..9.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle transmit request strobe, as produced by the team's edge one-shot.
REQ-006 SHALL have port data_in  input  DATA_WIDTH  payload; sampled only in the cycle a start is accepted.
REQ-007 SHALL have port tx  output  1  serial line; idle level 1.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY is reachable only when the REQ-026 option is compiled in.
REQ-011 SHALL accept start only when the FSM is in IDLE; on acceptance it latches data_in into a shift register and enters START.
REQ-012 SHALL ignore start while busy=1; the in-flight frame and the latched data are unaffected.
REQ-013 SHALL drive tx from a register, with all outputs glitch-free; tx SHALL go to 0 in the first cycle after the accepting edge (1-cycle latency).
REQ-014 SHALL hold every bit on tx for exactly CLKS_PER_BIT cycles, timed by a baud counter that restarts from 0 at each bit boundary.
REQ-015 SHALL transmit START=0, then DATA_WIDTH data bits LSB first, then the optional parity bit, then STOP=1.
REQ-016 SHALL count data bits with a bit index that runs 0..DATA_WIDTH-1; after the last bit it leaves DATA with no wrap and no extra bit.
REQ-017 SHALL assert busy from the first cycle of START through the last cycle of STOP, and SHALL deassert it when the FSM returns to IDLE.
REQ-018 SHALL assert done for exactly one cycle, in the first IDLE cycle after STOP; done and busy=0 coincide.
REQ-019 SHALL accept a start that coincides with the done cycle, giving back-to-back frames with no extra idle bit.
REQ-020 SHALL hold tx=1 in IDLE indefinitely while no start arrives.
REQ-021 SHALL give one frame length of (2 + DATA_WIDTH + P) x CLKS_PER_BIT cycles, where P=1 with parity and P=0 without.

Reset
REQ-022 SHALL, while reset=1, asynchronously force: FSM=IDLE, tx=1, busy=0, done=0, baud counter=0, bit index=0, shift register=0.
REQ-023 SHALL, on a reset mid-frame, abort the frame immediately and raise tx to 1 without waiting for a clock edge; no done is produced.
REQ-024 SHALL ignore a start asserted while reset=1.
REQ-025 SHALL accept a start in the first clock edge after reset deasserts.

Configuration
REQ-026 SHALL, when macro UART_TX_PARITY_EN is defined, insert one even-parity bit after the data bits; its value is the XOR of the latched data bits, lasting CLKS_PER_BIT cycles.
REQ-027 SHALL, when UART_TX_PARITY_EN is undefined, transition from the last data bit directly to STOP; the PARITY state and its logic are absent.

Verification
REQ-028 SHALL cover this basic frame: CLKS_PER_BIT=4, no parity, data_in=8'hA5 with start pulsed once -> tx=0,1,0,1,0,0,1,0,1,1 (4 cycles each), busy high for 40 cycles, then done=1 for 1 cycle.
REQ-029 SHALL cover parity: UART_TX_PARITY_EN defined, data_in=8'hA5 -> parity bit 0 after data, frame 44 cycles; data_in=8'h07 -> parity bit 1.
REQ-030 SHALL cover a start ignored while busy: start pulsed 10 cycles into an 8'hA5 frame with data_in=8'h3C -> the frame is still 8'hA5, and exactly one done is produced.
REQ-031 SHALL cover back-to-back frames: start asserted on the done cycle with data_in=8'h0F -> START bit begins in the next cycle, two contiguous frames, two done pulses.
REQ-032 SHALL cover reset mid-frame: reset asserted 17 cycles into a frame -> tx=1 and busy=0 within the same cycle, no done; a new start after reset releases sends a complete frame.
REQ-033 SHALL cover the boundary value CLKS_PER_BIT=2 with DATA_WIDTH=5 and data_in=5'h1F -> each bit lasts 2 cycles and the frame is 14 cycles.
